// File: rtl/omer_pkg.sv
// ---------------------------------------------------------------------------
// omer_pkg
// Shared types for the kamus instruction-fetch slice.
//   fetch_state_e : fetch FSM states (BOOT, RUN, FLUSH)
//   NOP_INSTR     : canonical RISC-V NOP (addi x0,x0,0) used for fault entries
//   CNT_W         : width of the outstanding/drop counters (covers 2*depth 4)
//   fetch_entry_t : one instruction-buffer entry {instr, pc, err}
// ---------------------------------------------------------------------------
package omer_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Counters must hold old in-flight responses plus new ones issued right
  // after a reset, so they are sized for twice the deepest buffer.
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        err;
  } fetch_entry_t;

endpackage

// File: rtl/kamus_fetch_fifo.sv
// ---------------------------------------------------------------------------
// kamus_fetch_fifo
// Small circular instruction buffer between the fetch unit and the decoder.
// DEPTH must be a power of two (2 or 4) so the pointers wrap naturally.
// Ports:
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_flush          : empty the buffer (wins over push and pop)
//   i_push/i_pushData: write one entry; allowed when full if popping too
//   i_pop            : drop the head entry (ignored when empty)
//   o_head           : current head entry
//   o_full, o_empty  : occupancy flags
//   o_count          : number of valid entries
// ---------------------------------------------------------------------------
module kamus_fetch_fifo
  import omer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  fetch_entry_t             i_pushData,
  input  logic                     i_pop,
  output fetch_entry_t             o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0]   r_rdPtr;
  logic [PTR_W-1:0]   r_wrPtr;
  logic [PTR_W:0]     r_count;
  logic               w_doPush;
  logic               w_doPop;

  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_head  = r_mem[r_rdPtr];
  assign o_count = r_count;

  // Pointer and occupancy bookkeeping; flush simply rewinds everything.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      r_count <= r_count + (PTR_W+1)'(w_doPush) - (PTR_W+1)'(w_doPop);
    end
  end

  // Storage needs no reset: contents are only visible while count > 0.
  always_ff @(posedge i_clk) begin
    if (w_doPush && !i_rst && !i_flush) r_mem[r_wrPtr] <= i_pushData;
  end

endmodule

// File: rtl/kamus_if.sv
// ---------------------------------------------------------------------------
// kamus_if
// Instruction fetch unit: issues word fetches to instruction memory under a
// credit scheme, buffers in-order responses and hands {instr, pc} to decode.
// Redirects flush the buffer and discard responses still in flight.
// Optional feature macro: KAMUS_FETCH_MISALIGN_EN -- misaligned redirect
// targets produce a single faulting NOP entry (fetch_err_o) and halt fetch.
// Ports:
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   imem_req_o/addr_o/gnt_i      : request channel (addr held until granted)
//   imem_rvalid_i/rdata_i        : in-order response channel
//   redirect_i/redirect_pc_i     : control-flow change from later stages
//   instr_valid_o/ready_i        : handshake toward the decoder
//   instr_o, pc_o                : head instruction and its address
//   fetch_err_o                  : misaligned-target fault (macro builds only)
// ---------------------------------------------------------------------------
module kamus_if
  import omer_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
`ifdef KAMUS_FETCH_MISALIGN_EN
  ,
  output logic        fetch_err_o
`endif
);

  fetch_state_e                  r_state;
  fetch_state_e                  w_stateNext;
  logic [31:0]                   r_fetchPc;
  logic [31:0]                   r_rspPc;
  logic [31:0]                   w_target;
  logic [CNT_W-1:0]              r_out;
  logic [CNT_W-1:0]              r_drop;
  logic [CNT_W-1:0]              w_inFlight;
  logic [CNT_W-1:0]              w_dropLoad;
  logic [CNT_W-1:0]              w_free;
  logic                          r_halt;
  logic                          r_errPending;
  logic                          w_grant;
  logic                          w_keep;
  logic                          w_discard;
  logic                          w_errPush;
  logic                          w_push;
  logic                          w_pop;
  fetch_entry_t                  w_pushData;
  fetch_entry_t                  w_head;
  logic                          w_full;
  logic                          w_empty;
  logic [$clog2(FIFO_DEPTH):0]   w_count;

`ifdef KAMUS_FETCH_MISALIGN_EN
  assign w_target = redirect_pc_i;
`else
  assign w_target = redirect_pc_i & 32'hFFFF_FFFC;
`endif

  assign w_free     = CNT_W'(FIFO_DEPTH) - CNT_W'(w_count);
  assign w_grant    = imem_req_o && imem_gnt_i;
  assign w_discard  = imem_rvalid_i && (r_drop != '0);
  assign w_keep     = imem_rvalid_i && (r_drop == '0);

  // Everything still in flight (old drops plus live requests) becomes the
  // new drop count on redirect or reset, less a response landing right now.
  assign w_inFlight = r_drop + r_out;
  assign w_dropLoad = w_inFlight - CNT_W'(imem_rvalid_i && (w_inFlight != '0));

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= BOOT;
    else       r_state <= w_stateNext;
  end

  // Next-state logic: a redirect only needs FLUSH if responses remain.
  always_comb begin
    w_stateNext = r_state;
    if (redirect_i) begin
      w_stateNext = (w_dropLoad != '0) ? FLUSH : RUN;
    end else begin
      case (r_state)
        BOOT:    w_stateNext = RUN;
        RUN:     w_stateNext = RUN;
        FLUSH:   if (r_drop == '0) w_stateNext = RUN;
        default: w_stateNext = BOOT;
      endcase
    end
  end

  // Request only while buffer space not already promised to in-flight
  // responses remains, so a push can never find the buffer full.
  always_comb begin
    imem_req_o = 1'b0;
    if ((r_state == RUN) && !redirect_i && !r_halt && !w_full && (w_free > r_out))
      imem_req_o = 1'b1;
  end

  assign imem_addr_o = r_fetchPc;

  // Live/drop counters; redirect and reset both turn live requests into drops.
  always_ff @(posedge clk_i) begin
    if (rst_i || redirect_i) begin
      r_out  <= '0;
      r_drop <= w_dropLoad;
    end else begin
      r_out  <= r_out + CNT_W'(w_grant) - CNT_W'(w_keep);
      r_drop <= r_drop - CNT_W'(w_discard);
    end
  end

  // r_fetchPc is the next request address; r_rspPc tags the next kept response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fetchPc <= BOOT_ADDR;
      r_rspPc   <= BOOT_ADDR;
    end else if (redirect_i) begin
      r_fetchPc <= w_target;
      r_rspPc   <= w_target;
    end else begin
      if (w_grant) r_fetchPc <= r_fetchPc + 32'd4;
      if (w_keep)  r_rspPc   <= r_rspPc + 32'd4;
    end
  end

`ifdef KAMUS_FETCH_MISALIGN_EN
  // A misaligned target halts fetch until the next redirect and owes the
  // decoder one faulting entry once stale responses have drained.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_halt       <= 1'b0;
      r_errPending <= 1'b0;
    end else if (redirect_i) begin
      r_halt       <= |w_target[1:0];
      r_errPending <= |w_target[1:0];
    end else if (w_errPush) begin
      r_errPending <= 1'b0;
    end
  end
`else
  // Targets are always aligned here, so fetch never halts.
  always_ff @(posedge clk_i) begin
    r_halt       <= 1'b0;
    r_errPending <= 1'b0;
  end
`endif

  assign w_errPush = r_errPending && (r_state == RUN) && (r_drop == '0) && !imem_rvalid_i;
  assign w_push    = !redirect_i && (w_keep || w_errPush);
  assign w_pop     = instr_valid_o && instr_ready_i && !redirect_i;

  // Build the entry to enqueue: a real response or the faulting NOP.
  always_comb begin
    w_pushData = '{instr: imem_rdata_i, pc: r_rspPc, err: 1'b0};
    if (w_errPush) w_pushData = '{instr: NOP_INSTR, pc: r_rspPc, err: 1'b1};
  end

  kamus_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_flush    (redirect_i),
    .i_push     (w_push),
    .i_pushData (w_pushData),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count)
  );

  // Outputs read zero while the buffer is empty, matching the reset view.
  assign instr_valid_o = !w_empty;
  assign instr_o       = w_empty ? 32'h0 : w_head.instr;
  assign pc_o          = w_empty ? 32'h0 : w_head.pc;

`ifdef KAMUS_FETCH_MISALIGN_EN
  assign fetch_err_o = !w_empty && w_head.err;
`else
  logic w_unusedErr;
  assign w_unusedErr = w_head.err;
`endif

endmodule

// File: tb/tb_kamus_if.sv
// ---------------------------------------------------------------------------
// tb_kamus_if
// Directed bench for kamus_if with an in-order memory responder and a
// decoder-side expectation of the pc/instr stream. Optional feature macro:
// KAMUS_FETCH_MISALIGN_EN (adds the faulting-redirect scenario).
// ---------------------------------------------------------------------------
module tb_kamus_if;

  localparam int          DEPTH   = 2;
  localparam logic [31:0] BOOT_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
`ifdef KAMUS_FETCH_MISALIGN_EN
  logic        fetch_err_o;
`endif

  always #5 clk_i = ~clk_i;

  kamus_if #(
    .BOOT_ADDR  (BOOT_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o)
`ifdef KAMUS_FETCH_MISALIGN_EN
    ,
    .fetch_err_o   (fetch_err_o)
`endif
  );

  int          errCount   = 0;
  int          checkCount = 0;
  logic [31:0] memQ[$];
  logic [31:0] expAddr;
  logic [31:0] expPc;
  int          cycleCnt   = 0;
  int          nGrant     = 0;
  int          nAccept    = 0;
  int          firstRv    = -1;
  int          firstValid = -1;
  bit          sbEn       = 1'b1;
  logic        sReq, sValid, sErr;
  logic [31:0] sAddr, sInstr, sPc;

  // Memory contents are a simple function of the address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] alignTarget(input logic [31:0] t);
`ifdef KAMUS_FETCH_MISALIGN_EN
    return t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // One clock cycle: drive inputs, sample outputs mid-cycle, update the
  // memory responder and the expected-stream model, then step the clock.
  task automatic applyStimulus(input logic gnt, input logic rspEn, input logic ready,
                               input logic redir, input logic [31:0] target);
    logic [31:0] a;
    imem_gnt_i    = gnt;
    instr_ready_i = ready;
    redirect_i    = redir;
    redirect_pc_i = target;
    if (rspEn && memQ.size() > 0) begin
      a = memQ.pop_front();
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = memWord(a);
      if (firstRv < 0) firstRv = cycleCnt;
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'h0;
    end
    #3;
    sReq   = imem_req_o;
    sAddr  = imem_addr_o;
    sValid = instr_valid_o;
    sInstr = instr_o;
    sPc    = pc_o;
`ifdef KAMUS_FETCH_MISALIGN_EN
    sErr   = fetch_err_o;
`else
    sErr   = 1'b0;
`endif
    if (sValid && firstValid < 0) firstValid = cycleCnt;
    if (sReq && gnt) begin
      nGrant++;
      if (sbEn) checkOutput("grantAddr", sAddr, expAddr);
      expAddr = expAddr + 32'd4;
      memQ.push_back(sAddr);
    end
    if (sValid && ready && !redir) begin
      nAccept++;
      if (sbEn) begin
        checkOutput("pc", sPc, expPc);
        checkOutput("instr", sInstr, memWord(expPc));
        checkOutput("errFlag", {31'b0, sErr}, 32'h0);
      end
      expPc = expPc + 32'd4;
    end
    if (redir) begin
      expAddr = alignTarget(target);
      expPc   = alignTarget(target);
    end
    @(posedge clk_i);
    #1;
    cycleCnt++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   g0;
    int   a0;
    bit   haveHead;
    bit   got;
    logic [31:0] holdInstr;
    logic [31:0] holdPc;

    rst_i         = 1'b1;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    instr_ready_i = 1'b0;
    expAddr       = BOOT_PC;
    expPc         = BOOT_PC;
    @(posedge clk_i);
    #1;

    $display("[TB] reset");
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rstReq",   {31'b0, sReq},   32'h0);
    checkOutput("rstValid", {31'b0, sValid}, 32'h0);
    checkOutput("rstInstr", sInstr, 32'h0);
    checkOutput("rstPc",    sPc,    32'h0);
    checkOutput("rstErr",   {31'b0, sErr},   32'h0);
    rst_i = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("bootReq", {31'b0, sReq}, 32'h0);

    $display("[TB] streaming");
    repeat (20) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("firstValidLatency", 32'(firstValid - firstRv), 32'd1);
    checkOutput("streamAccepts", 32'(nAccept >= 8), 32'd1);

    $display("[TB] decoder stall");
    g0 = nGrant;
    haveHead = 1'b0;
    holdInstr = 32'h0;
    holdPc = 32'h0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      if (sValid) begin
        if (!haveHead) begin
          haveHead  = 1'b1;
          holdInstr = sInstr;
          holdPc    = sPc;
          checkOutput("stallHeadPc", holdPc, expPc);
        end else begin
          checkOutput("stallInstr", sInstr, holdInstr);
          checkOutput("stallPc",    sPc,    holdPc);
        end
      end
    end
    checkOutput("stallGrants", 32'((nGrant - g0) <= DEPTH), 32'd1);
    checkOutput("stallValid",  {31'b0, sValid}, 32'h1);
    checkOutput("stallFullReq", {31'b0, sReq},  32'h0);
    a0 = nAccept;
    repeat (12) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("stallResume", 32'((nAccept - a0) >= 4), 32'd1);

    $display("[TB] redirect with outstanding");
    repeat (6) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("outstandingCap", 32'(memQ.size()), 32'(DEPTH));
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
    checkOutput("redirReq", {31'b0, sReq}, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("validAfterRedir", {31'b0, sValid}, 32'h0);
    a0 = nAccept;
    repeat (15) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("redirAccepts", 32'((nAccept - a0) >= 4), 32'd1);

    $display("[TB] grant withheld and address wrap");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      if (sReq) got = 1'b1;
    end
    checkOutput("wrapReqSeen", {31'b0, got}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("holdReq",  {31'b0, sReq}, 32'h1);
      checkOutput("holdAddr", sAddr, 32'hFFFF_FFF8);
    end
    a0 = nAccept;
    repeat (15) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("wrapAccepts", 32'((nAccept - a0) >= 4), 32'd1);

`ifdef KAMUS_FETCH_MISALIGN_EN
    $display("[TB] misaligned redirect");
    sbEn = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0102);
    checkOutput("misRedirReq", {31'b0, sReq}, 32'h0);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("misNoReq", {31'b0, sReq}, 32'h0);
      if (sValid) got = 1'b1;
    end
    checkOutput("misEntrySeen", {31'b0, got}, 32'h1);
    checkOutput("misPc",    sPc,    32'h0000_0102);
    checkOutput("misInstr", sInstr, 32'h0000_0013);
    checkOutput("misErr",   {31'b0, sErr}, 32'h1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("misHaltValid", {31'b0, sValid}, 32'h0);
      checkOutput("misHaltReq",   {31'b0, sReq},   32'h0);
    end
    sbEn = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0200);
    a0 = nAccept;
    repeat (12) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("misResume", 32'((nAccept - a0) >= 3), 32'd1);
`else
    $display("[TB] unaligned target is forced aligned");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0203);
    a0 = nAccept;
    repeat (12) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("alignAccepts", 32'((nAccept - a0) >= 3), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/kamus_if.md
KAMUS_IF -- requirements
Module: kamus_if

Interface
REQ-001 SHALL have parameter BOOT_ADDR, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2: instruction buffer entries; legal values 2 and 4.
REQ-003 SHALL have port clk_i  in  1: single clock, all state on rising edge.
REQ-004 SHALL have port rst_i  in  1: reset, synchronous, active-high.
REQ-005 SHALL have port imem_req_o  out  1: fetch request valid.
REQ-006 SHALL have port imem_addr_o  out  32: word-aligned fetch address.
REQ-007 SHALL have port imem_gnt_i  in  1: request accepted this cycle.
REQ-008 SHALL have port imem_rvalid_i  in  1: response valid; responses return in request order.
REQ-009 SHALL have port imem_rdata_i  in  32: response instruction word.
REQ-010 SHALL have port redirect_i  in  1: control-flow change (branch/jump/trap) from later stage.
REQ-011 SHALL have port redirect_pc_i  in  32: new fetch target.
REQ-012 SHALL have port instr_valid_o  out  1: instr_o/pc_o valid toward decoder.
REQ-013 SHALL have port instr_ready_i  in  1: decoder accepts this cycle.
REQ-014 SHALL have port instr_o  out  32: raw instruction, fed to the decoder's instr_i.
REQ-015 SHALL have port pc_o  out  32: address of instr_o.
REQ-016 SHALL have port fetch_err_o  out  1: misaligned-target fault marker (present only under KAMUS_FETCH_MISALIGN_EN).

Function
REQ-017 SHALL implement FSM states BOOT, RUN, FLUSH; BOOT -> RUN after one cycle; RUN -> FLUSH on redirect_i with responses outstanding; FLUSH -> RUN when drop count reaches 0.
REQ-018 SHALL assert imem_req_o in RUN only when (free FIFO slots - outstanding requests) > 0, never in BOOT or FLUSH or in a redirect cycle.
REQ-019 SHALL hold imem_addr_o stable while imem_req_o is high and imem_gnt_i low; request withdrawn only by redirect_i.
REQ-020 SHALL increment fetch PC by 4 on imem_req_o && imem_gnt_i, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-021 SHALL track outstanding count 0..FIFO_DEPTH: +1 on grant, -1 on accepted rvalid, both in one cycle -> unchanged.
REQ-022 SHALL push {rdata, pc} into the FIFO on imem_rvalid_i when drop count is 0; latency rvalid -> instr_valid_o is exactly 1 cycle.
REQ-023 SHALL pop FIFO head on instr_valid_o && instr_ready_i; instr_o/pc_o held stable while valid && !ready.
REQ-024 SHALL allow push and pop in the same cycle, including when full; credit rule of REQ-018 guarantees no overflow.
REQ-025 SHALL on redirect_i: empty FIFO, load fetch PC with redirect_pc_i, set drop count = outstanding minus any rvalid that cycle; redirect_i has priority over push, pop and grant.
REQ-026 SHALL discard each rvalid while drop count > 0, decrementing it; instr_valid_o low in the cycle after a redirect.
REQ-027 SHALL, without KAMUS_FETCH_MISALIGN_EN, force redirect_pc_i[1:0] to 2'b00.

Reset
REQ-028 SHALL on rst_i: state BOOT, fetch PC = BOOT_ADDR, FIFO empty, outstanding = 0, drop = 0, imem_req_o = 0, instr_valid_o = 0, instr_o = 0, pc_o = 0, fetch_err_o = 0.
REQ-029 SHALL treat reset mid-transaction as flush: in-flight responses after reset are ignored for the old outstanding count (drop count loaded from pre-reset outstanding).

Configuration
REQ-030 SHALL with KAMUS_FETCH_MISALIGN_EN defined: redirect target with [1:0] != 0 issues no request, enqueues one entry {instr 32'h0000_0013, pc = target, fetch_err_o = 1}, then fetch halts until the next redirect_i.
REQ-031 SHALL without KAMUS_FETCH_MISALIGN_EN: fetch_err_o port absent, REQ-027 applies.

Structure
REQ-032 SHALL place fetch FSM enum (fetch_state_e), NOP constant and fetch-entry struct (fetch_entry_t: instr, pc, err) in omer_pkg.
REQ-033 SHALL instantiate sub-module kamus_fetch_fifo (parameterised depth, push/pop/flush, full/empty/count) for the buffer.

Verification
REQ-034 SHALL cover reset release, gnt and rvalid always 1, ready 1 -> addresses 0,4,8,...; instr_valid_o first high 1 cycle after first rvalid, pc_o 0,4,8.
REQ-035 SHALL cover ready held 0 for 10 cycles -> at most FIFO_DEPTH grants, instr_o/pc_o stable, no entry lost or duplicated after ready returns.
REQ-036 SHALL cover redirect to 32'h0000_0100 with 2 outstanding -> next 2 rvalids dropped, next pc_o = 32'h100, no stale pc_o.
REQ-037 SHALL cover gnt withheld 5 cycles -> imem_addr_o constant; fetch PC 32'hFFFF_FFFC granted -> next address 0.
REQ-038 SHALL cover (macro on) redirect to 32'h0000_0102 -> one entry pc_o 32'h102, instr_o 32'h13, fetch_err_o 1, imem_req_o stays 0 until next redirect.
